// File: rtl/mdio_pkg.sv
// Shared definitions for the MDIO station-management generator and the PHY-side receiver.
package mdio_pkg;

    localparam int unsigned CMD_W  = 32;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned CNT_W  = 6;

    // Bit positions of the Clause-22 fields inside t_data
    localparam int unsigned ST_POS    = 30;
    localparam int unsigned OP_POS    = 28;
    localparam int unsigned PHYAD_POS = 23;
    localparam int unsigned REGAD_POS = 18;
    localparam int unsigned TA_POS    = 16;
    localparam int unsigned WDATA_POS = 0;

    localparam logic [1:0] ST_START = 2'b01;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_READ  = 2'b10;

    typedef enum logic [6:0] {
        S_IDLE    = 7'b000_0001,
        S_PRE     = 7'b000_0010,
        S_CMD     = 7'b000_0100,
        S_WR      = 7'b000_1000,
        S_RD_TA   = 7'b001_0000,
        S_RD_DATA = 7'b010_0000,
        S_DONE    = 7'b100_0000
    } mdio_state_e;

    typedef struct packed {
        logic [1:0]        st;
        logic [1:0]        op;
        logic [4:0]        phyad;
        logic [4:0]        regad;
        logic [1:0]        ta;
        logic [DATA_W-1:0] wdata;
    } mdio_cmd_t;

    // Split a raw command word into its fields
    function automatic mdio_cmd_t unpack_cmd(input logic [CMD_W-1:0] w);
        mdio_cmd_t c;
        c.st    = w[ST_POS +: 2];
        c.op    = w[OP_POS +: 2];
        c.phyad = w[PHYAD_POS +: 5];
        c.regad = w[REGAD_POS +: 5];
        c.ta    = w[TA_POS +: 2];
        c.wdata = w[WDATA_POS +: DATA_W];
        return c;
    endfunction

    // Only Clause-22 write and read frames are generated
    function automatic logic cmd_valid(input mdio_cmd_t c);
        return (c.st == ST_START) && ((c.op == OP_WRITE) || (c.op == OP_READ));
    endfunction

endpackage

// File: rtl/mdio_generador_clkdiv.sv
// MDC divider: toggles every DIV clks while enabled, starting low, with edge strobes.
module mdio_clkdiv #(
    parameter int unsigned DIV = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic en_i,
    output logic mdc_o,
    output logic rise_evt_c,
    output logic fall_evt_c
);

    localparam int unsigned DIV_W = 8;

    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic             mdc_q, mdc_d;
    logic             wrap_c;

    assign wrap_c     = en_i && (cnt_q == DIV_W'(DIV - 1));
    assign rise_evt_c = wrap_c && !mdc_q;
    assign fall_evt_c = wrap_c && mdc_q;
    assign mdc_o      = mdc_q;

    // Next divider count and MDC level; idle forces MDC low and clears the count
    always_comb begin
        cnt_d = cnt_q;
        mdc_d = mdc_q;
        if (!en_i) begin
            cnt_d = '0;
            mdc_d = 1'b0;
        end else if (wrap_c) begin
            cnt_d = '0;
            mdc_d = !mdc_q;
        end else begin
            cnt_d = cnt_q + DIV_W'(1);
        end
    end

    // Divider state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
            mdc_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            mdc_q <= mdc_d;
        end
    end

endmodule

// File: rtl/mdio_generador.sv
// MDIO station-management frame generator: MDC, serial command/data out, read-data capture.
module mdio_generador
    import mdio_pkg::*;
#(
    parameter int unsigned DIV     = 1,
    parameter int unsigned PRE_LEN = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mdio_start,
    input  logic [CMD_W-1:0]  t_data,
    input  logic              mdio_in,
    output logic              MDC,
    output logic              mdio_oe,
    output logic              mdio_out,
    output logic              mdio_done,
    output logic [DATA_W-1:0] rd_data,
    output logic              data_rdy,
    output logic              busy
);

    mdio_state_e       state_q, state_d;
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [CMD_W-1:0]  shreg_q, shreg_d;
    logic [DATA_W-1:0] rd_shift_q, rd_shift_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic              is_read_q, is_read_d;
    logic              oe_q, oe_d;
    logic              out_q, out_d;
    logic              done_q, done_d;
    logic              rdy_q, rdy_d;
    logic              busy_q, busy_d;

    mdio_cmd_t         cmd_c;
    logic              div_en_c;
    logic              rise_c, fall_c;
    logic              last_pre_c, last_word_c;

    assign cmd_c       = unpack_cmd(t_data);
    assign div_en_c    = (state_q != S_IDLE) && (state_q != S_DONE);
    assign last_pre_c  = (bit_cnt_q == CNT_W'(PRE_LEN - 1));
    assign last_word_c = (bit_cnt_q == CNT_W'(DATA_W - 1));

    mdio_clkdiv #(
        .DIV (DIV)
    ) u_clkdiv (
        .clk        (clk),
        .rst        (rst),
        .en_i       (div_en_c),
        .mdc_o      (MDC),
        .rise_evt_c (rise_c),
        .fall_evt_c (fall_c)
    );

    // Frame sequencing: bits advance on MDC falling strobes, read data sampled on rising strobes
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shreg_d    = shreg_q;
        rd_shift_d = rd_shift_q;
        rd_data_d  = rd_data_q;
        is_read_d  = is_read_q;
        oe_d       = oe_q;
        out_d      = out_q;
        done_d     = 1'b0;
        rdy_d      = 1'b0;
        busy_d     = busy_q;

        unique case (state_q)
            S_IDLE: begin
                if (mdio_start && cmd_valid(cmd_c)) begin
                    shreg_d   = cmd_c;
                    is_read_d = (cmd_c.op == OP_READ);
                    busy_d    = 1'b1;
                    bit_cnt_d = '0;
                    oe_d      = 1'b1;
                    if (PRE_LEN > 0) begin
                        state_d = S_PRE;
                        out_d   = 1'b1;
                    end else begin
                        state_d = S_CMD;
                        out_d   = cmd_c.st[1];
                    end
                end
            end
            S_PRE: begin
                if (fall_c) begin
                    if (last_pre_c) begin
                        state_d   = S_CMD;
                        bit_cnt_d = '0;
                        out_d     = shreg_q[CMD_W-1];
                    end else begin
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    end
                end
            end
            S_CMD: begin
                if (fall_c) begin
                    shreg_d = shreg_q << 1;
                    if (last_word_c) begin
                        bit_cnt_d = '0;
                        if (is_read_q) begin
                            state_d = S_RD_TA;
                            oe_d    = 1'b0;
                            out_d   = 1'b0;
                        end else begin
                            state_d = S_WR;
                            out_d   = shreg_q[CMD_W-2];
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                        out_d     = shreg_q[CMD_W-2];
                    end
                end
            end
            S_WR: begin
                if (fall_c) begin
                    shreg_d = shreg_q << 1;
                    if (last_word_c) begin
                        state_d   = S_DONE;
                        bit_cnt_d = '0;
                        oe_d      = 1'b0;
                        out_d     = 1'b0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                        out_d     = shreg_q[CMD_W-2];
                    end
                end
            end
            S_RD_TA: begin
                // PHY owns the line during turnaround; mdio_in is not looked at
                if (fall_c) begin
                    if (bit_cnt_q == CNT_W'(1)) begin
                        state_d   = S_RD_DATA;
                        bit_cnt_d = '0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    end
                end
            end
            S_RD_DATA: begin
                if (rise_c) begin
                    rd_shift_d = {rd_shift_q[DATA_W-2:0], mdio_in};
                end
                if (fall_c) begin
                    if (last_word_c) begin
                        state_d   = S_DONE;
                        bit_cnt_d = '0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                oe_d    = 1'b0;
                out_d   = 1'b0;
                if (is_read_q) begin
                    rd_data_d = rd_shift_q;
                    rdy_d     = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
                oe_d    = 1'b0;
                out_d   = 1'b0;
            end
        endcase
    end

    // State and output registers; reset aborts any frame in flight
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            bit_cnt_q  <= '0;
            shreg_q    <= '0;
            rd_shift_q <= '0;
            rd_data_q  <= '0;
            is_read_q  <= 1'b0;
            oe_q       <= 1'b0;
            out_q      <= 1'b0;
            done_q     <= 1'b0;
            rdy_q      <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shreg_q    <= shreg_d;
            rd_shift_q <= rd_shift_d;
            rd_data_q  <= rd_data_d;
            is_read_q  <= is_read_d;
            oe_q       <= oe_d;
            out_q      <= out_d;
            done_q     <= done_d;
            rdy_q      <= rdy_d;
            busy_q     <= busy_d;
        end
    end

    assign mdio_oe   = oe_q;
    assign mdio_out  = out_q;
    assign mdio_done = done_q;
    assign rd_data   = rd_data_q;
    assign data_rdy  = rdy_q;
    assign busy      = busy_q;

endmodule
